dbg_cap_wr_ctrl: RTL and testbench
==================================

DBG_CAP_WR_CTRL -- requirements
Module: dbg_cap_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, sample and RAM data width.
REQ-003 SHALL have port clk, input, 1, single clock for all logic; the RAM write port is driven in this domain.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cfg_start, input, 1, single-cycle pulse that arms a capture.
REQ-006 SHALL have port cfg_abort, input, 1, single-cycle pulse that cancels the current operation.
REQ-007 SHALL have port cfg_len, input, ADDR_WIDTH, capture length in samples; 0 means 4096.
REQ-008 SHALL have port din_vld, input, 1, ADC sample valid.
REQ-009 SHALL have port din, input, DATA_WIDTH, ADC sample.
REQ-010 SHALL have port trig, input, 1, trigger, qualified by din_vld.
REQ-011 SHALL have port ram_cs, output, 1, RAM write-port chip select (active high).
REQ-012 SHALL have port ram_wr, output, 1, RAM write enable (active high).
REQ-013 SHALL have port ram_addr, output, ADDR_WIDTH, RAM write address.
REQ-014 SHALL have port ram_din, output, DATA_WIDTH, RAM write data.
REQ-015 SHALL have port busy, output, 1, high in ARMED or CAPTURE.
REQ-016 SHALL have port done, output, 1, sticky capture-complete flag.
REQ-017 SHALL have port start_addr, output, ADDR_WIDTH, RAM address of the first valid captured sample.

Function
REQ-018 SHALL implement FSM states IDLE, ARMED, CAPTURE and DONE.
REQ-019 SHALL move IDLE or DONE -> ARMED on cfg_start, clear done and set the write pointer to 0 on that transition, and ignore cfg_start in ARMED or CAPTURE.
REQ-020 SHALL move ARMED -> CAPTURE on din_vld&trig, write that triggering sample as the first sample, and ignore trig that arrives without din_vld.
REQ-021 SHALL write, in CAPTURE, each din_vld sample at the write pointer and then increment the pointer, wrapping from 4095 to 0.
REQ-022 SHALL register RAM writes with one-cycle latency: ram_cs=ram_wr=1 exactly on the cycle after each accepted sample, with ram_addr and ram_din held from that sample, and ram_cs=ram_wr=0 otherwise.
REQ-023 SHALL move CAPTURE -> DONE when the post-trigger write count reaches the target (cfg_len, or 4096 when cfg_len=0), set done=1, and accept no further samples.
REQ-024 SHALL make cfg_abort take priority over cfg_start and trig: in any state it forces IDLE on the next cycle, writes no sample that cycle, and leaves done unchanged.
REQ-025 SHALL sample cfg_len on entry to ARMED and ignore later changes until the next arm.
REQ-026 SHALL report start_addr = 0 when the pre-trigger feature is compiled out.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, set state=IDLE, ram_cs=0, ram_wr=0, ram_addr=0, ram_din=0, busy=0, done=0, start_addr=0, and clear the pointer and counters.
REQ-028 SHALL give rst priority over all other inputs, abandon a capture that is in progress, and complete no RAM write on the cycle after rst.

Configuration
REQ-029 SHALL, when macro DBG_CAP_PRETRIG_EN is defined, add an input cfg_pretrig (ADDR_WIDTH, legal when less than the target length).
REQ-030 SHALL, with DBG_CAP_PRETRIG_EN, write every din_vld sample in ARMED as a ring buffer and count pre-trigger samples up to a saturation limit of cfg_pretrig.
REQ-031 SHALL, with DBG_CAP_PRETRIG_EN, capture (target - cfg_pretrig) samples in CAPTURE, including the trigger sample.
REQ-032 SHALL, with DBG_CAP_PRETRIG_EN, set start_addr = (trigger address - saturated pre-trigger count) mod 4096 on trigger.
REQ-033 SHALL, without DBG_CAP_PRETRIG_EN, have no cfg_pretrig port, write nothing in ARMED, and behave exactly as REQ-018..026.

Verification
REQ-034 SHALL cover basic capture: cfg_len=8, arm, din_vld continuous, trig on sample 0x0A00 -> 8 writes at addresses 0..7 with data 0x0A00..0x0A07, done=1 the cycle after the last write, busy=0.
REQ-035 SHALL cover gapped valid: cfg_len=4, din_vld toggling 1010..., trig on the first valid -> exactly 4 writes at addresses 0..3, each one cycle after its valid, and no writes on idle cycles.
REQ-036 SHALL cover full length: cfg_len=0 -> 4096 writes covering addresses 0..4095, then done=1 with no write to address 0 again.
REQ-037 SHALL cover abort: abort after 3 capture writes with cfg_len=10 -> state IDLE, done=0, no 4th write; a simultaneous start+abort in IDLE -> stays IDLE.
REQ-038 SHALL cover reset mid-capture: rst pulse at write 5 -> all outputs 0 the next cycle, and a re-arm restarts at address 0.
REQ-039 SHALL cover pre-trigger with DBG_CAP_PRETRIG_EN: cfg_len=16, cfg_pretrig=4, 10 ARMED samples, trig at address 10 -> start_addr=6, 12 capture writes at 10..21, done=1.

Source files
------------

// File: rtl/dbg_cap_wr_ctrl.sv
// Debug capture RAM write controller: arm, wait for trigger, stream samples into RAM.
// Latency: one cycle from an accepted sample to its registered RAM write strobe.
// Backpressure: none; samples arriving while idle, done or on an abort cycle are dropped.
// Optional pre-trigger ring buffer is enabled by defining DBG_CAP_PRETRIG_EN.
module dbg_cap_wr_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
`ifdef DBG_CAP_PRETRIG_EN
    input  logic [ADDR_WIDTH-1:0] cfg_pretrig,
`endif
    input  logic                  din_vld,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  trig,
    output logic                  ram_cs,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] start_addr
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [CW-1:0]         target_q;
    logic [CW-1:0]         post_len;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_nxt;
    logic                  done_q;
    logic                  arm;
    logic                  wr_en;
    logic                  trig_hit;
    logic                  finish;

`ifdef DBG_CAP_PRETRIG_EN
    logic [ADDR_WIDTH-1:0] pretrig_q;
    logic [ADDR_WIDTH-1:0] pre_cnt_q;
    logic [ADDR_WIDTH-1:0] start_addr_q;

    assign post_len   = target_q - {1'b0, pretrig_q};
    assign start_addr = start_addr_q;
`else
    assign post_len   = target_q;
    assign start_addr = '0;
`endif

    // The trigger sample is post-trigger write number one.
    assign cnt_nxt = (state_q == ARMED) ? CW'(1) : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        arm       = 1'b0;
        wr_en     = 1'b0;
        trig_hit  = 1'b0;
        finish    = 1'b0;
        if (cfg_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (cfg_start) begin
                        state_nxt = ARMED;
                        arm       = 1'b1;
                    end
                end
                ARMED: begin
                    if (din_vld && trig) begin
                        trig_hit = 1'b1;
                        wr_en    = 1'b1;
                        if (cnt_nxt >= post_len) begin
                            finish    = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            state_nxt = CAPTURE;
                        end
                    end
`ifdef DBG_CAP_PRETRIG_EN
                    else if (din_vld) begin
                        wr_en = 1'b1;
                    end
`endif
                end
                CAPTURE: begin
                    if (din_vld) begin
                        wr_en = 1'b1;
                        if (cnt_nxt >= post_len) begin
                            finish    = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_cs   <= 1'b0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            wr_ptr_q <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            ram_cs <= wr_en;
            ram_wr <= wr_en;
            if (wr_en) begin
                ram_addr <= wr_ptr_q;
                ram_din  <= din;
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (arm) begin
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                done_q   <= 1'b0;
                target_q <= (cfg_len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, cfg_len};
            end
            if (trig_hit || (wr_en && state_q == CAPTURE)) begin
                cnt_q <= cnt_nxt;
            end
            if (finish) begin
                done_q <= 1'b1;
            end
        end
    end

`ifdef DBG_CAP_PRETRIG_EN
    // Pre-trigger depth saturates so start_addr never points past the oldest kept sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            pretrig_q    <= '0;
            pre_cnt_q    <= '0;
            start_addr_q <= '0;
        end else begin
            if (arm) begin
                pretrig_q <= cfg_pretrig;
                pre_cnt_q <= '0;
            end
            if (wr_en && !trig_hit && state_q == ARMED && pre_cnt_q < pretrig_q) begin
                pre_cnt_q <= pre_cnt_q + ADDR_WIDTH'(1);
            end
            if (trig_hit) begin
                start_addr_q <= wr_ptr_q - pre_cnt_q;
            end
        end
    end
`endif

    assign busy = (state_q == ARMED) || (state_q == CAPTURE);
    assign done = done_q;

endmodule

// File: tb/tb_dbg_cap_wr_ctrl.sv
// Bench for dbg_cap_wr_ctrl: scenario tasks checked against a sample-list reference model.
module tb_dbg_cap_wr_ctrl;
    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;
    localparam int MAXN  = 4200;
`ifdef DBG_CAP_PRETRIG_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic          cfg_abort;
    logic [AW-1:0] cfg_len;
`ifdef DBG_CAP_PRETRIG_EN
    logic [AW-1:0] cfg_pretrig;
`endif
    logic          din_vld;
    logic [DW-1:0] din;
    logic          trig;
    logic          ram_cs;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          busy;
    logic          done;
    logic [AW-1:0] start_addr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Observed RAM writes: address, data, cycle index
    int wa[$];
    int wd[$];
    int wc[$];

    // Stimulus tables consumed by run_scenario
    logic          sv[MAXN];
    logic          st[MAXN];
    logic [DW-1:0] sd[MAXN];

    dbg_cap_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .cfg_len    (cfg_len),
`ifdef DBG_CAP_PRETRIG_EN
        .cfg_pretrig(cfg_pretrig),
`endif
        .din_vld    (din_vld),
        .din        (din),
        .trig       (trig),
        .ram_cs     (ram_cs),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .busy       (busy),
        .done       (done),
        .start_addr (start_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_cs === 1'b1 || ram_wr === 1'b1) begin
            checks++;
            if (ram_wr !== ram_cs) begin
                errors++;
                $display("FAIL strobe_pair: ram_cs=%b ram_wr=%b (must be equal)", ram_cs, ram_wr);
            end
            if (ram_cs === 1'b1) begin
                wa.push_back(int'(ram_addr));
                wd.push_back(int'(ram_din));
                wc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_writes();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic set_pretrig(input int pre);
`ifdef DBG_CAP_PRETRIG_EN
        cfg_pretrig = AW'(pre);
`endif
    endtask

    task automatic fill_table(input int n);
        for (int i = 0; i < n; i++) begin
            sv[i] = 1'b1;
            st[i] = 1'b0;
            sd[i] = DW'(i);
        end
    endtask

    // Arms, plays the stimulus tables, compares against the reference, then aborts.
    task automatic run_scenario(input string name, input int len, input int pre, input int n);
        int ea[$];
        int ed[$];
        int ec[$];
        int target, post, a, pc, k, sa, base;
        bit started, fin, bad;
        clear_writes();
        cfg_len = AW'(len);
        set_pretrig(pre);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_len   = AW'($urandom);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s arm: busy=%b done=%b want busy=1 done=0", name, busy, done);
        end
        base = cyc + 1;
        for (int i = 0; i < n; i++) begin
            din_vld = sv[i];
            trig    = st[i];
            din     = sd[i];
            tick();
        end
        din_vld = 1'b0;
        trig    = 1'b0;
        tick();
        tick();

        target  = (len % DEPTH == 0) ? DEPTH : len % DEPTH;
        post    = target - pre;
        a       = 0;
        pc      = 0;
        k       = 0;
        sa      = 0;
        started = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!started) begin
                if (sv[i] && st[i]) begin
                    started = 1'b1;
                    sa = PRE_EN ? (((a - pc) % DEPTH) + DEPTH) % DEPTH : 0;
                end else if (sv[i] && PRE_EN) begin
                    ea.push_back(a % DEPTH);
                    ed.push_back(int'(sd[i]));
                    ec.push_back(base + i);
                    a++;
                    if (pc < pre) pc++;
                end
            end
            if (started && sv[i] && k < post) begin
                ea.push_back(a % DEPTH);
                ed.push_back(int'(sd[i]));
                ec.push_back(base + i);
                a++;
                k++;
            end
        end
        fin = started && (k == post);

        checks++;
        if (wa.size() != ea.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, wa.size(), ea.size());
        end
        bad = 1'b0;
        for (int i = 0; i < ea.size() && i < wa.size() && !bad; i++) begin
            checks++;
            if (wa[i] != ea[i] || wd[i] != ed[i] || wc[i] != ec[i]) begin
                errors++;
                bad = 1'b1;
                $display("FAIL %s write[%0d]: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         name, i, wa[i], wd[i], wc[i], ea[i], ed[i], ec[i]);
            end
        end
        checks++;
        if (done !== (fin ? 1'b1 : 1'b0) || busy !== (fin ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL %s end_state: done=%b busy=%b want done=%b busy=%b", name, done, busy, fin, !fin);
        end
        if (started) begin
            checks++;
            if (start_addr !== AW'(sa)) begin
                errors++;
                $display("FAIL %s start_addr: got %0d want %0d", name, start_addr, sa);
            end
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== (fin ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL %s abort_cleanup: busy=%b done=%b want busy=0 done=%b", name, busy, done, fin);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cfg_start = 1'b1;
        din_vld   = 1'b1;
        trig      = 1'b1;
        tick();
        cfg_start = 1'b0;
        din_vld   = 1'b0;
        trig      = 1'b0;
        tick();
        checks++;
        if ({ram_cs, ram_wr, busy, done} !== 4'b0000 || ram_addr !== '0 || ram_din !== '0 || start_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: cs=%b wr=%b busy=%b done=%b addr=%0d din=%h start=%0d want all 0",
                     ram_cs, ram_wr, busy, done, ram_addr, ram_din, start_addr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b ram_cs=%b want 0 0", busy, ram_cs);
        end
    endtask

    task automatic test_basic();
        fill_table(14);
        for (int i = 0; i < 14; i++) sd[i] = DW'(16'h0A00 - 2 + i);
        sv[0] = 1'b0;
        st[0] = 1'b1;
        st[2] = 1'b1;
        run_scenario("basic", 8, 0, 14);
    endtask

    task automatic test_gapped();
        fill_table(12);
        for (int i = 0; i < 12; i++) begin
            sv[i] = (i % 2 == 0);
            sd[i] = DW'($urandom);
        end
        st[0] = 1'b1;
        run_scenario("gapped", 4, 0, 12);
    endtask

    task automatic test_random();
        int len, pre;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 24);
            pre = PRE_EN ? $urandom_range(0, len - 1) : 0;
            for (int i = 0; i < 60; i++) begin
                sv[i] = ($urandom_range(0, 3) != 0);
                st[i] = ($urandom_range(0, 9) == 0);
                sd[i] = DW'($urandom);
            end
            run_scenario($sformatf("random%0d", r), len, pre, 60);
        end
    endtask

    task automatic test_full_length();
        fill_table(4110);
        st[0] = 1'b1;
        run_scenario("full_length", 0, 0, 4110);
    endtask

    task automatic test_abort();
        clear_writes();
        set_pretrig(0);
        cfg_len   = AW'(10);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_vld = 1'b1;
            trig    = (i == 0);
            din     = DW'(16'h0200 + i);
            tick();
        end
        cfg_abort = 1'b1;
        din       = DW'(16'h0203);
        tick();
        cfg_abort = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        din_vld = 1'b0;
        tick();
        checks++;
        if (wa.size() != 3 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_capture: writes=%0d busy=%b done=%b want 3 0 0", wa.size(), busy, done);
        end else begin
            checks++;
            if (wa[2] != 2 || wd[2] != 16'h0202) begin
                errors++;
                $display("FAIL abort_last_write: addr=%0d data=%h want 2 0202", wa[2], wd[2]);
            end
        end
        clear_writes();
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_busy: busy=%b want 0", busy);
        end
        din_vld = 1'b1;
        trig    = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        din_vld = 1'b0;
        trig    = 1'b0;
        tick();
        checks++;
        if (wa.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: writes=%0d busy=%b want 0 0", wa.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        clear_writes();
        set_pretrig(0);
        cfg_len   = AW'(12);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_vld = 1'b1;
            trig    = (i == 0);
            din     = DW'(16'h0100 + i);
            tick();
        end
        rst = 1'b1;
        din = DW'(16'h0105);
        tick();
        rst     = 1'b0;
        din_vld = 1'b0;
        checks++;
        if ({ram_cs, ram_wr, busy, done} !== 4'b0000 || ram_addr !== '0 || ram_din !== '0 || start_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: cs=%b wr=%b busy=%b done=%b addr=%0d din=%h want all 0",
                     ram_cs, ram_wr, busy, done, ram_addr, ram_din);
        end
        tick();
        checks++;
        if (wa.size() != 5) begin
            errors++;
            $display("FAIL reset_mid_writes: got %0d want 5", wa.size());
        end
        fill_table(6);
        st[0] = 1'b1;
        for (int i = 0; i < 6; i++) sd[i] = DW'(16'h0C00 + i);
        run_scenario("rearm", 3, 0, 6);
    endtask

`ifdef DBG_CAP_PRETRIG_EN
    task automatic test_pretrig();
        fill_table(30);
        for (int i = 0; i < 30; i++) sd[i] = DW'(16'h0300 + i);
        st[10] = 1'b1;
        run_scenario("pretrig", 16, 4, 30);
        checks++;
        if (start_addr !== 12'd6) begin
            errors++;
            $display("FAIL pretrig_start_addr: got %0d want 6", start_addr);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_len   = '0;
        din_vld   = 1'b0;
        din       = '0;
        trig      = 1'b0;
        set_pretrig(0);
        test_reset();
        test_basic();
        test_gapped();
        test_random();
        test_full_length();
        test_abort();
        test_reset_mid();
`ifdef DBG_CAP_PRETRIG_EN
        test_pretrig();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
